// File: rtl/data_memory.sv
// data_memory: word-addressed data memory on the datapath load/store bus.
// Each access waits WAIT_CYCLES states and then retires in the DONE state,
// which raises Ready for exactly one cycle. The memory contents are cleared by reset.
// Optional feature macro: DMEM_LED_PORT_EN. When it is defined, the all-ones word
// index maps to the led output register instead of to memory.
module data_memory #(
    parameter int NBITS       = 8,
    parameter int NWORDS      = 2**(NBITS-2),
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:2] Address,
    input  logic [NBITS-1:0] WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [NBITS-1:0] ReadData,
    output logic             Ready,
    output logic             Busy,
    output logic [NBITS-1:0] led
);

    localparam int AW = NBITS - 2;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = WAIT_CYCLES[3:0];
    localparam logic [AW:0] NWORDS_W  = NWORDS[AW:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [NBITS-1:0] wdata_q, wdata_d;
    logic             wr_q, wr_d;

    logic [NBITS-1:0] mem_q [NWORDS];
    logic [NBITS-1:0] rdata_q;
    logic             ready_q;
    logic             busy_q;
    logic [NBITS-1:0] led_q;

    // Operands seen by the retiring access. In IDLE with zero wait states the
    // access retires on the accepting edge, so the live inputs are used directly.
    logic [AW-1:0]    acc_addr_s;
    logic [NBITS-1:0] acc_wdata_s;
    logic             acc_wr_s;
    logic             retire_s;
    logic             in_range_s;
    logic             led_hit_s;
    logic             mem_hit_s;
    logic [IW-1:0]    mem_idx_s;
    logic [NBITS-1:0] rd_val_s;

    // Next-state logic: accept in IDLE, count down in WAIT, retire through DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        acc_addr_s  = addr_q;
        acc_wdata_s = wdata_q;
        acc_wr_s    = wr_q;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d      = Address;
                    wdata_d     = WriteData;
                    wr_d        = MemWrite;
                    cnt_d       = WAIT_INIT;
                    acc_addr_s  = Address;
                    acc_wdata_s = WriteData;
                    acc_wr_s    = MemWrite;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = WAIT;
                end
            end
            DONE: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Address decode and read mux for the retiring access.
    always_comb begin
        retire_s   = (state_d == DONE) && (state_q != DONE);
        in_range_s = ({1'b0, acc_addr_s} < NWORDS_W);
        mem_idx_s  = acc_addr_s[IW-1:0];
`ifdef DMEM_LED_PORT_EN
        led_hit_s  = (acc_addr_s == {AW{1'b1}});
`else
        led_hit_s  = 1'b0;
`endif
        mem_hit_s  = in_range_s && !led_hit_s;
        if (led_hit_s) begin
            rd_val_s = led_q;
        end else if (mem_hit_s) begin
            rd_val_s = mem_q[mem_idx_s];
        end else begin
            rd_val_s = {NBITS{1'b0}};
        end
    end

    // Control state, latched operands and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= {AW{1'b0}};
            wdata_q <= {NBITS{1'b0}};
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= {NBITS{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            ready_q <= retire_s;
            busy_q  <= (state_d != IDLE);
            if (retire_s && !acc_wr_s) begin
                rdata_q <= rd_val_s;
            end
        end
    end

    // Memory array: cleared by reset, written when a store retires in range.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem_q[i] <= {NBITS{1'b0}};
            end
        end else if (retire_s && acc_wr_s && mem_hit_s) begin
            mem_q[mem_idx_s] <= acc_wdata_s;
        end
    end

    // Memory-mapped led register, updated when a store to its index retires.
    always_ff @(posedge clock) begin
        if (reset) begin
            led_q <= {NBITS{1'b0}};
        end else if (retire_s && acc_wr_s && led_hit_s) begin
            led_q <= acc_wdata_s;
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign led      = led_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory. Instance 0 uses NBITS=8, WAIT_CYCLES=2 and full depth.
// Instance 1 uses WAIT_CYCLES=0 and NWORDS=16, so it also exercises the out-of-range path.
// Stimulus pushes the expected ReadData. A monitor per instance pops it on each Ready.
module tb_data_memory;

    logic       clock;
    logic       reset;
    logic [7:2] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       rd0, rd1, wr0, wr1;
    logic [7:0] rdata0, rdata1;
    logic       ready0, ready1;
    logic       busy0, busy1;
    logic [7:0] led0, led1;

    int compared;
    int failed;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last_rd [2];

    data_memory #(.NBITS(8), .NWORDS(64), .WAIT_CYCLES(2)) dut0 (
        .clock(clock), .reset(reset), .Address(addr0), .WriteData(wdata0),
        .MemRead(rd0), .MemWrite(wr0), .ReadData(rdata0), .Ready(ready0),
        .Busy(busy0), .led(led0)
    );

    data_memory #(.NBITS(8), .NWORDS(16), .WAIT_CYCLES(0)) dut1 (
        .clock(clock), .reset(reset), .Address(addr1), .WriteData(wdata1),
        .MemRead(rd1), .MemWrite(wr1), .ReadData(rdata1), .Ready(ready1),
        .Busy(busy1), .led(led1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor for instance 0.
    always @(negedge clock) begin
        if (!reset && ready0) begin
            compared++;
            if (q0.size() == 0) begin
                failed++;
                $display("FAIL dut0_unexpected_ready: got Ready=1 expected no access pending");
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (rdata0 !== e) begin
                    failed++;
                    $display("FAIL dut0_readdata: got 0x%0h expected 0x%0h", rdata0, e);
                end
            end
        end
    end

    // Monitor for instance 1.
    always @(negedge clock) begin
        if (!reset && ready1) begin
            compared++;
            if (q1.size() == 0) begin
                failed++;
                $display("FAIL dut1_unexpected_ready: got Ready=1 expected no access pending");
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (rdata1 !== e) begin
                    failed++;
                    $display("FAIL dut1_readdata: got 0x%0h expected 0x%0h", rdata1, e);
                end
            end
        end
    end

    task automatic drive(input bit which, input bit r, input bit w, input logic [5:0] a, input logic [7:0] d);
        if (which) begin
            rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end else begin
            rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    function automatic logic rdy(input bit which);
        return which ? ready1 : ready0;
    endfunction

    function automatic logic bsy(input bit which);
        return which ? busy1 : busy0;
    endfunction

    // One access, started at a negedge. It optionally swaps the operands during the first WAIT cycle.
    // It returns on the negedge after Ready, so the caller can issue the next request right away.
    task automatic access(input bit which, input bit r, input bit w,
                          input logic [5:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input int exp_lat,
                          input bit chg, input logic [5:0] a2, input logic [7:0] d2,
                          input string nm);
        int n;
        int busy_n;
        logic [7:0] e;
        e = (r && !w) ? exp_rd : last_rd[which];
        last_rd[which] = e;
        if (which) q1.push_back(e);
        else       q0.push_back(e);
        drive(which, r, w, a, d);
        n = 0;
        busy_n = 0;
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (bsy(which)) busy_n++;
            if (chg && n == 1) drive(which, r, w, a2, d2);
            if (rdy(which)) break;
        end
        drive(which, 1'b0, 1'b0, a, d);
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_busy_cycles"}, busy_n, exp_lat);
        @(negedge clock);
        chk({nm, "_busy_after"}, {31'd0, bsy(which)}, 32'd0);
    endtask

    initial begin
        logic [7:0] exp_led;
        compared = 0;
        failed = 0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 8'h00);
        repeat (3) @(negedge clock);
        chk("reset_readdata", rdata0, 8'h00);
        chk("reset_ready", ready0, 1'b0);
        chk("reset_busy", busy0, 1'b0);
        chk("reset_led", led0, 8'h00);
        chk("reset_busy1", busy1, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Reset during the WAIT of a store: no Ready, no write.
        drive(1'b0, 1'b0, 1'b1, 6'd9, 8'h3C);
        @(negedge clock);
        chk("midreset_busy_in_wait", busy0, 1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 6'd0, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clock);
                if (ready0) seen++;
            end
            chk("midreset_no_ready", seen, 0);
        end
        chk("midreset_busy", busy0, 1'b0);
        access(1'b0, 1'b1, 1'b0, 6'd9, 8'h00, 8'h00, 3, 1'b0, 6'd0, 8'h00, "load9_after_reset");

        // Store then load, back to back.
        access(1'b0, 1'b0, 1'b1, 6'd5, 8'hA5, 8'h00, 3, 1'b0, 6'd0, 8'h00, "store5");
        access(1'b0, 1'b1, 1'b0, 6'd5, 8'h00, 8'hA5, 3, 1'b0, 6'd0, 8'h00, "load5");

        // Collision: a write that leaves ReadData holding 0x11.
        access(1'b0, 1'b0, 1'b1, 6'd3, 8'h11, 8'h00, 3, 1'b0, 6'd0, 8'h00, "store3");
        access(1'b0, 1'b1, 1'b0, 6'd3, 8'h00, 8'h11, 3, 1'b0, 6'd0, 8'h00, "load3");
        access(1'b0, 1'b1, 1'b1, 6'd2, 8'h7E, 8'h00, 3, 1'b0, 6'd0, 8'h00, "collide2");
        chk("collide_hold", rdata0, 8'h11);
        access(1'b0, 1'b1, 1'b0, 6'd2, 8'h00, 8'h7E, 3, 1'b0, 6'd0, 8'h00, "load2");

        // Operands change during WAIT and are ignored.
        access(1'b0, 1'b0, 1'b1, 6'd4, 8'h55, 8'h00, 3, 1'b1, 6'd6, 8'hEE, "store4_chg");
        access(1'b0, 1'b1, 1'b0, 6'd4, 8'h00, 8'h55, 3, 1'b0, 6'd0, 8'h00, "load4");
        access(1'b0, 1'b1, 1'b0, 6'd6, 8'h00, 8'h00, 3, 1'b0, 6'd0, 8'h00, "load6");

        // Index 63: led register when the macro is defined, memory otherwise.
`ifdef DMEM_LED_PORT_EN
        exp_led = 8'hC3;
`else
        exp_led = 8'h00;
`endif
        chk("led_before", led0, 8'h00);
        access(1'b0, 1'b0, 1'b1, 6'd63, 8'hC3, 8'h00, 3, 1'b0, 6'd0, 8'h00, "store63");
        chk("led_after", led0, exp_led);
        access(1'b0, 1'b1, 1'b0, 6'd63, 8'h00, 8'hC3, 3, 1'b0, 6'd0, 8'h00, "load63");

        // Zero wait states and out-of-range accesses on instance 1.
        access(1'b1, 1'b0, 1'b1, 6'd0, 8'h01, 8'h00, 1, 1'b0, 6'd0, 8'h00, "zw_store0");
        access(1'b1, 1'b1, 1'b0, 6'd0, 8'h00, 8'h01, 1, 1'b0, 6'd0, 8'h00, "zw_load0");
        access(1'b1, 1'b0, 1'b1, 6'd20, 8'h99, 8'h00, 1, 1'b0, 6'd0, 8'h00, "oor_store20");
        access(1'b1, 1'b1, 1'b0, 6'd20, 8'h00, 8'h00, 1, 1'b0, 6'd0, 8'h00, "oor_load20");
        access(1'b1, 1'b1, 1'b0, 6'd4, 8'h00, 8'h00, 1, 1'b0, 6'd0, 8'h00, "oor_alias4");

        repeat (3) @(negedge clock);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
